// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, fills a small prefetch queue from a
// combinational word memory, and handles redirects. Optional macro: FETCH_PERF_EN (bubbleCount).
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_BYTES   = 512,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clock,
  input  logic        resetN,
  output logic [31:0] instructionAddress,
  input  logic [31:0] instructionIn,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  input  logic        decodeReady,
  output logic        instructionValid,
  output logic [31:0] instructionOut,
  output logic [31:0] instructionPc,
  output logic        fetchFault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] bubbleCount
`endif
);

  localparam int              PW        = $clog2(QUEUE_DEPTH);
  localparam int              CW        = PW + 1;
  localparam logic [31:0]     LAST_WORD = 32'(MEM_BYTES - 4);
  localparam logic [CW-1:0]   DEPTH_C   = CW'(QUEUE_DEPTH);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [PW-1:0]   PTR_ONE   = PW'(1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  // The range check alone catches run-off before fetchPc + 4 can wrap to 0.
  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= LAST_WORD);
  endfunction

  entry_t        queue_q [QUEUE_DEPTH];
  entry_t        queue_d [QUEUE_DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          fault_q, fault_d;
  logic          pop_s, push_s, space_s;

  assign instructionAddress = fetch_pc_q;
  assign instructionValid   = (count_q != {CW{1'b0}});
  assign instructionOut     = queue_q[head_q].word;
  assign instructionPc      = queue_q[head_q].pc;
  assign fetchFault         = fault_q;

  // Handshake, queue bookkeeping, PC advance and fault tracking.
  always_comb begin
    queue_d    = queue_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    fault_d    = fault_q;
    pop_s      = instructionValid && decodeReady;
    space_s    = (count_q < DEPTH_C) || pop_s;
    push_s     = !redirectValid && !fault_q && legal(fetch_pc_q) && space_s;

    if (redirectValid) begin
      // Redirect wins over any same-cycle pop; the queue is simply flushed.
      head_d     = {PW{1'b0}};
      tail_d     = {PW{1'b0}};
      count_d    = {CW{1'b0}};
      fetch_pc_d = redirectTarget;
      fault_d    = !legal(redirectTarget);
    end else begin
      if (push_s) begin
        queue_d[tail_q] = '{pc: fetch_pc_q, word: instructionIn};
        tail_d          = tail_q + PTR_ONE;
        fetch_pc_d      = fetch_pc_q + 32'd4;
      end else if (!fault_q && space_s) begin
        fault_d = 1'b1;
      end else begin
        fault_d = fault_q;
      end

      if (pop_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset also zeroes queue storage so the head outputs read 0.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        queue_q[i] <= entry_t'(64'h0);
      end
      head_q     <= {PW{1'b0}};
      tail_q     <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      fetch_pc_q <= RESET_PC;
      fault_q    <= 1'b0;
    end else begin
      queue_q    <= queue_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      fault_q    <= fault_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] bubble_q, bubble_d;

  assign bubbleCount = bubble_q;

  // Saturating count of cycles with nothing presented to decode.
  always_comb begin
    bubble_d = bubble_q;
    if (!instructionValid && (bubble_q != 32'hFFFF_FFFF)) begin
      bubble_d = bubble_q + 32'd1;
    end else begin
      bubble_d = bubble_q;
    end
  end

  // Bubble counter register; redirects do not clear it.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      bubble_q <= 32'h0000_0000;
    end else begin
      bubble_q <= bubble_d;
    end
  end
`endif

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction memory interface.
- Owns the fetch PC and drives the byte address into the combinational, big-endian, word-wide instruction memory.
- Captures the returned word into a small prefetch queue and presents it to decode with a valid/ready handshake.
- Handles branch/jump redirects: flushes the queue and restarts fetch at the target. Flags illegal fetch addresses.

Parameters:
- RESET_PC, 32'h0000_0000: fetch address after reset.
- MEM_BYTES, 512: size of instruction memory in bytes. Legal fetch requires addr+3 <= MEM_BYTES-1.
- QUEUE_DEPTH, 2: prefetch queue entries. Power of two, minimum 2.

Ports:
- clock  in  1  rising-edge clock
- resetN  in  1  asynchronous active-low reset
- instructionAddress  out  32  byte address to instruction memory; equals fetchPc
- instructionIn  in  32  word returned by memory, same cycle (combinational)
- redirectValid  in  1  one-cycle pulse: branch/jump taken
- redirectTarget  in  32  new fetch byte address, sampled when redirectValid=1
- decodeReady  in  1  decode accepts the head entry this cycle
- instructionValid  out  1  queue non-empty and no fault pending at head
- instructionOut  out  32  head instruction word
- instructionPc  out  32  byte address of head instruction
- fetchFault  out  1  sticky illegal-fetch flag

Behaviour:
- Reset (async assert, sync release):
  - fetchPc = RESET_PC; queue empty; fetchFault = 0.
  - instructionValid = 0; instructionOut = 0; instructionPc = 0.
- Internal signals:
  - pop = instructionValid & decodeReady.
  - push = !redirectValid & !fetchFault & legal(fetchPc) & (count < QUEUE_DEPTH | pop).
  - legal(a) = (a[1:0] == 0) & (a <= MEM_BYTES-4).
- On push:
  - Enqueue {fetchPc, instructionIn}.
  - fetchPc <= fetchPc + 4.
- When queue is full and there is no pop: fetchPc holds, so instructionAddress is stable.
- Push and pop may occur in the same cycle; count is unchanged.
- The queue is FIFO. Head/tail pointers wrap modulo QUEUE_DEPTH.
- Latency:
  - A word fetched in cycle N is presented at the head in cycle N+1 if the queue was empty.
  - Steady-state throughput is 1 instruction/cycle with decodeReady held high.
- Redirect (redirectValid=1):
  - Queue is flushed, count = 0. Any pop in the same cycle is discarded; redirect wins.
  - fetchPc <= redirectTarget. No push this cycle.
  - fetchFault <= !legal(redirectTarget).
  - instructionValid = 0 in the following cycle; the first target instruction is valid one cycle later (1-bubble redirect penalty).
- Fault:
  - If fetchPc is not legal at a would-be push, fetchFault is set and fetch stops.
  - Entries already queued still drain normally.
  - fetchFault clears only on a redirect to a legal target, or on reset.
  - Sequential run-off: fetchPc = MEM_BYTES-4 is fetched; the next address MEM_BYTES faults. There is no wrap to 0.
- Width rules: fetchPc + 4 is 32-bit modulo, but the legality check catches overrun before wrap.
- Reset asserted mid-operation immediately clears the queue and all outputs, regardless of clock.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output port bubbleCount (32 bits).
  - Reset to 0.
  - Increments on each cycle with instructionValid=0 and resetN=1.
  - Saturates at 32'hFFFF_FFFF.
  - Is not cleared by redirect.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset release, decodeReady=1, memory holds addi at 0 and sw at 4:
  - instructionAddress = 0, then 4, 8 on successive cycles.
  - First valid cycle shows instructionOut=32'h2108_0008, instructionPc=0.
  - Next valid cycle shows 32'hAC08_0000, instructionPc=4.
- decodeReady=0 for 5 cycles from reset:
  - Queue fills to 2 entries (PC 0, 4); instructionAddress holds 8.
  - Raise decodeReady: entries 0, 4, 8 delivered in order with no gap.
- Redirect to 32'h40 while queue holds 2 entries:
  - Next cycle instructionValid=0.
  - Following cycle instructionPc=32'h40.
  - Old entries are never presented.
- Redirect to 32'h42 (misaligned): fetchFault=1 next cycle, instructionValid stays 0. Redirect to 32'h10: fetchFault=0 and fetch resumes at 32'h10.
- Redirect to MEM_BYTES-8 = 504, decodeReady=1:
  - PCs 504 and 508 are delivered.
  - fetchFault rises when fetchPc=512.
  - No PC 0 entry appears.
- With FETCH_PERF_EN defined, reset then one redirect under decodeReady=1: bubbleCount = 2 (1 reset bubble + 1 redirect bubble).
